if_id_pipe_stage: RTL and testbench

IF_ID_PIPE_STAGE -- requirements
Module: if_id_pipe_stage

---
 rtl/if_id_pipe_stage_pkg.sv | 19 +
 rtl/if_id_pipe_stage_entry_reg.sv | 44 ++++
 rtl/if_id_pipe_stage.sv | 166 ++++++++++++++++
 tb/tb_if_id_pipe_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pipe_stage_pkg.sv
// rtl/if_id_pipe_stage_pkg.sv - shared encodings for the IF/ID pipeline stage
package if_id_pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JAL    = 2'd2,
        NPC_JALR   = 2'd3
    } next_pc_sel_e;

endpackage

// File: rtl/if_id_pipe_stage_entry_reg.sv
// rtl/if_id_pipe_stage_entry_reg.sv - one valid+payload holding register
module if_id_entry_reg
    import if_id_pipe_stage_pkg::*;
#(
    parameter int WIDTH = 52
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Clearing drops only the valid bit; the payload is kept so the PC stays visible.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/if_id_pipe_stage.sv
// rtl/if_id_pipe_stage.sv - IF/ID handshake register; IF_ID_SKID_EN selects a 2-entry skid buffer
module if_id_pipe_stage
    import if_id_pipe_stage_pkg::*;
#(
    parameter int                    CORE         = 0,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDRESS_BITS = 20,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(NOP_DEFAULT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    if_valid,
    output logic                    if_ready,
    input  logic [DATA_WIDTH-1:0]   if_instruction,
    input  logic [ADDRESS_BITS-1:0] if_inst_PC,
    output logic                    id_valid,
    input  logic                    id_ready,
    output logic [DATA_WIDTH-1:0]   id_instruction,
    output logic [ADDRESS_BITS-1:0] id_inst_PC,
    input  logic                    id_flush,
    input  logic                    id_branch,
    input  logic [ADDRESS_BITS-1:0] id_branch_target,
    input  logic [ADDRESS_BITS-1:0] id_JAL_target,
    input  logic [ADDRESS_BITS-1:0] id_JALR_target,
    input  logic [1:0]              id_next_PC_select,
    output logic                    if_branch,
    output logic [ADDRESS_BITS-1:0] if_branch_target,
    output logic [ADDRESS_BITS-1:0] if_JAL_target,
    output logic [ADDRESS_BITS-1:0] if_JALR_target,
    output logic [1:0]              if_next_PC_select,
    output logic [15:0]             stall_cycles
);

    localparam int PW = DATA_WIDTH + ADDRESS_BITS;
    localparam int RW = 1 + 3 * ADDRESS_BITS + 2;

    if (CORE < 0) begin : g_core_check
        $error("CORE index must be non-negative");
    end

    logic          alive_q, alive_d;
    logic          head_valid, head_load, head_clr;
    logic [PW-1:0] head_data, head_in, incoming;
    logic          accept, drain;
    logic [15:0]   stall_d, stall_q;
    logic [RW-1:0] redir_d, redir_q;

    assign incoming = {if_instruction, if_inst_PC};
    assign accept   = if_valid && if_ready;
    assign drain    = head_valid && id_ready;

    if_id_entry_reg #(.WIDTH(PW)) u_head (
        .clock     (clock),
        .reset     (reset),
        .load      (head_load),
        .clr       (head_clr),
        .data_in   (head_in),
        .valid_out (head_valid),
        .data_out  (head_data)
    );

`ifdef IF_ID_SKID_EN
    occ_state_e    state_d, state_q;
    logic          ready_d, ready_q;
    logic          skid_valid, skid_load, skid_clr;
    logic [PW-1:0] skid_data;

    if_id_entry_reg #(.WIDTH(PW)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load),
        .clr       (skid_clr),
        .data_in   (incoming),
        .valid_out (skid_valid),
        .data_out  (skid_data)
    );

    always_comb begin
        state_d   = state_q;
        head_load = 1'b0;
        head_clr  = 1'b0;
        head_in   = incoming;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (id_flush) begin
            state_d  = ST_EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    head_load = 1'b1;
                    state_d   = ST_ONE;
                end
                ST_ONE: if (accept && drain) begin
                    head_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = ST_FULL;
                end else if (drain) begin
                    head_clr = 1'b1;
                    state_d  = ST_EMPTY;
                end
                ST_FULL: if (drain && skid_valid) begin
                    head_load = 1'b1;
                    head_in   = skid_data;
                    skid_clr  = 1'b1;
                    state_d   = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // id_ready never reaches if_ready here; only the flush bypass is combinational.
    assign if_ready = alive_q && (ready_q || id_flush);
`else
    always_comb begin
        head_in   = incoming;
        head_load = accept && !id_flush;
        head_clr  = id_flush || (drain && !accept);
    end

    assign if_ready = alive_q && (!head_valid || id_ready || id_flush);
`endif

    always_comb begin
        alive_d = 1'b1;
        stall_d = stall_q;
        if (head_valid && !id_ready && !id_flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        redir_d = {id_branch, id_branch_target, id_JAL_target, id_JALR_target, id_next_PC_select};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alive_q <= 1'b0;
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            alive_q <= alive_d;
            stall_q <= stall_d;
            redir_q <= redir_d;
        end
    end

    assign {if_branch, if_branch_target, if_JAL_target, if_JALR_target, if_next_PC_select} = redir_q;

    assign id_valid       = head_valid;
    assign id_instruction = head_valid ? head_data[PW-1:ADDRESS_BITS] : NOP_INSTR;
    assign id_inst_PC     = head_data[ADDRESS_BITS-1:0];
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb/tb_if_id_pipe_stage.sv - scoreboard bench for if_id_pipe_stage
module tb_if_id_pipe_stage;
    import if_id_pipe_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 20;
    localparam int PW = DW + AW;
    localparam int RW = 1 + 3 * AW + 2;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_valid, if_ready, id_valid, id_ready, id_flush;
    logic [DW-1:0] if_instruction, id_instruction;
    logic [AW-1:0] if_inst_PC, id_inst_PC;
    logic          id_branch, if_branch;
    logic [AW-1:0] id_branch_target, id_JAL_target, id_JALR_target;
    logic [AW-1:0] if_branch_target, if_JAL_target, if_JALR_target;
    logic [1:0]    id_next_PC_select, if_next_PC_select;
    logic [15:0]   stall_cycles;

    always #5 clock = ~clock;

    if_id_pipe_stage #(
        .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NOP_INSTR(NOP)
    ) dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instruction(if_instruction), .if_inst_PC(if_inst_PC),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instruction(id_instruction), .id_inst_PC(id_inst_PC),
        .id_flush(id_flush),
        .id_branch(id_branch), .id_branch_target(id_branch_target),
        .id_JAL_target(id_JAL_target), .id_JALR_target(id_JALR_target),
        .id_next_PC_select(id_next_PC_select),
        .if_branch(if_branch), .if_branch_target(if_branch_target),
        .if_JAL_target(if_JAL_target), .if_JALR_target(if_JALR_target),
        .if_next_PC_select(if_next_PC_select),
        .stall_cycles(stall_cycles)
    );

    logic [PW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    bit            alive_m = 1'b0;
    int            stall_m = 0;
    logic [RW-1:0] exp_rd = '0;
    logic [AW-1:0] last_pc = '0;
    bit            acc_s;
    int            acc_cnt;
    logic [AW-1:0] pc;

    bit            m_hv, m_fl, m_dr, m_rdy;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rd_out();
        return {if_branch, if_branch_target, if_JAL_target, if_JALR_target, if_next_PC_select};
    endfunction

    task automatic redirect_rand();
        id_branch         = 1'($urandom);
        id_branch_target  = AW'($urandom);
        id_JAL_target     = AW'($urandom);
        id_JALR_target    = AW'($urandom);
        id_next_PC_select = 2'($urandom);
    endtask

    task automatic inputs_rand();
        if_valid       = ($urandom % 4) != 0;
        id_ready       = ($urandom % 3) != 0;
        id_flush       = ($urandom % 24) == 0;
        if_instruction = $urandom;
        if_inst_PC     = AW'($urandom);
        redirect_rand();
    endtask

    task automatic model_reset();
        exp_q.delete();
        stall_m = 0;
        exp_rd  = '0;
        alive_m = 1'b0;
        last_pc = '0;
    endtask

    // Sample the handshake mid-cycle, then apply the spec rules at the edge.
    task automatic step();
        logic          fl, acc, stl;
        logic [PW-1:0] beat;
        logic [RW-1:0] rd;
        @(negedge clock);
        fl   = id_flush;
        acc  = if_valid && if_ready;
        beat = {if_instruction, if_inst_PC};
        stl  = (exp_q.size() != 0) && !id_ready && !id_flush;
        rd   = {id_branch, id_branch_target, id_JAL_target, id_JALR_target, id_next_PC_select};
        @(posedge clock);
        acc_s = acc && !fl;
        if (reset) begin
            if (fl) exp_q.delete();
            else if (acc) exp_q.push_back(beat);
            if (stl && stall_m < 65535) stall_m++;
            exp_rd  = rd;
            alive_m = 1'b1;
        end
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) begin
                m_hv = exp_q.size() != 0;
                chk("id_valid", id_valid, m_hv);
                if (m_hv) begin
                    chk("id_instruction", id_instruction, exp_q[0][PW-1:AW]);
                    chk("id_inst_PC", id_inst_PC, exp_q[0][AW-1:0]);
                    last_pc = exp_q[0][AW-1:0];
                end else begin
                    chk("nop_instruction", id_instruction, NOP);
                    chk("held_pc", id_inst_PC, last_pc);
                end
                if (SKID) m_rdy = alive_m && ((exp_q.size() < 2) || id_flush);
                else      m_rdy = alive_m && (!m_hv || id_ready || id_flush);
                chk("if_ready", if_ready, m_rdy);
                chk("redirect", rd_out(), exp_rd);
                chk("stall_cycles", stall_cycles, stall_m[15:0]);
                m_fl = id_flush;
                m_dr = m_hv && id_ready;
                @(posedge clock);
                if (m_dr && !m_fl && reset) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        if_valid = 0; id_ready = 0; id_flush = 0;
        if_instruction = '0; if_inst_PC = '0;
        redirect_rand();
        id_branch = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instruction", id_instruction, NOP);
        chk("rst_id_inst_PC", id_inst_PC, '0);
        chk("rst_if_ready", if_ready, 1'b0);
        chk("rst_redirect", rd_out(), '0);
        chk("rst_stall", stall_cycles, '0);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Streaming from reset release
        pc = 20'h100;
        if_valid = 1; id_ready = 1; if_inst_PC = pc; if_instruction = $urandom;
        repeat (6) begin
            step();
            if (acc_s) pc += 4;
            if_inst_PC = pc; if_instruction = $urandom;
            redirect_rand();
        end
        if_valid = 0;
        repeat (3) step();

        // Decode stall while fetch streams three PCs
        pc = 20'h100; acc_cnt = 0;
        id_ready = 0; if_valid = 1; if_inst_PC = pc; if_instruction = $urandom;
        id_branch = 1'b1; id_branch_target = 20'h2000;
        step();
        chk("branch_redirect", {if_branch, if_branch_target}, {1'b1, 20'h2000});
        if (acc_s) begin acc_cnt++; pc += 4; end
        if_inst_PC = pc; if_instruction = $urandom;
        repeat (2) begin
            step();
            if (acc_s) begin acc_cnt++; pc += 4; end
            if_inst_PC = pc; if_instruction = $urandom;
        end
        chk("stall_accepts", acc_cnt, SKID ? 2 : 1);
        id_ready = 1;
        repeat (8) begin
            if_valid = (pc <= 20'h108);
            step();
            if (acc_s) pc += 4;
            if_inst_PC = pc; if_instruction = $urandom;
        end
        if_valid = 0;
        repeat (2) step();

        // Flush a full buffer with a beat arriving on the same edge
        id_ready = 0; if_valid = 1;
        repeat (3) begin
            if_inst_PC = AW'($urandom); if_instruction = $urandom;
            step();
        end
        id_flush = 1; if_valid = 1; if_inst_PC = 20'hABCDE;
        step();
        id_flush = 0; if_valid = 0;
        chk("flush_id_valid", id_valid, 1'b0);
        chk("flush_nop", id_instruction, NOP);
        chk("flush_if_ready", if_ready, 1'b1);
        id_ready = 1;
        repeat (3) step();

        repeat (1500) begin
            inputs_rand();
            step();
        end

        // Stall long enough to saturate the counter
        id_flush = 0; id_ready = 0; if_valid = 1;
        if_inst_PC = AW'($urandom); if_instruction = $urandom;
        repeat (65600) step();
        chk("stall_saturated", stall_cycles, 16'hFFFF);

        // Asynchronous reset while holding beats
        #1;
        reset  = 1'b0;
        mon_en = 1'b0;
        model_reset();
        #1;
        chk("arst_id_valid", id_valid, 1'b0);
        chk("arst_nop", id_instruction, NOP);
        chk("arst_if_ready", if_ready, 1'b0);
        chk("arst_stall", stall_cycles, '0);
        chk("arst_redirect", rd_out(), '0);
        repeat (2) @(posedge clock);
        #2;
        reset  = 1'b1;
        mon_en = 1'b1;
        id_ready = 1; if_valid = 0;
        repeat (4) step();

        repeat (300) begin
            inputs_rand();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
